// File: rtl/awb_gain_apply.sv
// awb_gain_apply
//   Applies white-balance gains to a tagged 12-bit pixel stream.
//   The pipeline is two stages deep: gain selection and multiply, then
//   rounding and saturation. Gains are double-buffered (shadow/active).
//   Gains written while a frame is running are held in the shadow
//   registers and only take effect after the frame's last pixel, so a
//   single frame is never processed with two different gain sets.
//
// Ports
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   Din          : [15:4] pixel, [3:0] channel tag (bit2 R, bit1 B, bit3/bit0 G)
//   data_en      : Din valid this cycle
//   end_flag     : last pixel of the frame (qualified by data_en)
//   rGain/gGain/bGain : U2.6 gains, 0x40 = 1.0
//   gain_vld     : one-cycle strobe capturing the three gains
//   bypass       : (AWB_APPLY_BYPASS_EN only) pass Din through with the same latency
//   Dout         : {gained pixel, Din tag}
//   dout_en      : Dout valid
//   dout_end     : end_flag aligned with Dout
//   gain_pending : shadow gains waiting for the frame boundary
//
// Configuration
//   AWB_APPLY_BYPASS_EN : adds the bypass input.

module awb_gain_apply (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] Din,
  input  logic        data_en,
  input  logic        end_flag,
  input  logic [7:0]  rGain,
  input  logic [7:0]  gGain,
  input  logic [7:0]  bGain,
  input  logic        gain_vld,
`ifdef AWB_APPLY_BYPASS_EN
  input  logic        bypass,
`endif
  output logic [15:0] Dout,
  output logic        dout_en,
  output logic        dout_end,
  output logic        gain_pending
);

  localparam logic [7:0] UnityGain = 8'h40;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t     state;

  logic [7:0] shadowR, shadowG, shadowB;
  logic [7:0] activeR, activeG, activeB;

  logic       frameEnd;
  logic [7:0] selGain;
  logic [19:0] product;

  logic [19:0] prod1;
  logic [3:0]  tag1;
  logic        en1;
  logic        end1;
`ifdef AWB_APPLY_BYPASS_EN
  logic [11:0] pix1;
  logic        bypass1;
`endif

  logic [13:0] roundedPix;
  logic [11:0] satPix;

  assign frameEnd = data_en && end_flag;

  // Frame tracking and gain double-buffering. At the frame boundary the
  // active set takes the shadow values, or the strobed values directly if
  // gain_vld lands on the last pixel, so a late update is never lost.
  // The last pixel itself still sees the old active gains because stage 1
  // reads the registers before this update lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadowR      <= UnityGain;
      shadowG      <= UnityGain;
      shadowB      <= UnityGain;
      activeR      <= UnityGain;
      activeG      <= UnityGain;
      activeB      <= UnityGain;
      gain_pending <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (data_en && !end_flag) state <= ACTIVE;
        ACTIVE:  if (frameEnd)             state <= IDLE;
        default: state <= IDLE;
      endcase

      if (gain_vld) begin
        shadowR <= rGain;
        shadowG <= gGain;
        shadowB <= bGain;
      end

      if (frameEnd) begin
        activeR      <= gain_vld ? rGain : shadowR;
        activeG      <= gain_vld ? gGain : shadowG;
        activeB      <= gain_vld ? bGain : shadowB;
        gain_pending <= 1'b0;
      end else if (gain_vld) begin
        if (state == IDLE) begin
          activeR <= rGain;
          activeG <= gGain;
          activeB <= bGain;
        end else begin
          gain_pending <= 1'b1;
        end
      end
    end
  end

  // Tag decode with R > B > G priority; an untagged pixel passes at 1.0.
  always_comb begin
    selGain = UnityGain;
    if (Din[2])
      selGain = activeR;
    else if (Din[1])
      selGain = activeB;
    else if (Din[3] || Din[0])
      selGain = activeG;
    product = {8'd0, Din[15:4]} * {12'd0, selGain};
  end

  // Stage 1: register the product. Data registers only move on valid
  // pixels; the valid/end flags follow data_en every cycle so gaps propagate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod1   <= '0;
      tag1    <= '0;
      en1     <= 1'b0;
      end1    <= 1'b0;
`ifdef AWB_APPLY_BYPASS_EN
      pix1    <= '0;
      bypass1 <= 1'b0;
`endif
    end else begin
      en1  <= data_en;
      end1 <= frameEnd;
      if (data_en) begin
        prod1 <= product;
        tag1  <= Din[3:0];
`ifdef AWB_APPLY_BYPASS_EN
        pix1    <= Din[15:4];
        bypass1 <= bypass;
`endif
      end
    end
  end

  // Round to nearest by adding half an LSB of the U2.6 gain before the
  // shift. The maximum product (4095 x 255) plus 32 still fits in 20 bits,
  // so the sum cannot wrap.
  assign roundedPix = 14'((prod1 + 20'd32) >> 6);
  assign satPix     = (roundedPix > 14'd4095) ? 12'hFFF : roundedPix[11:0];

  // Stage 2: output register, updated only when stage 1 holds a pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Dout     <= '0;
      dout_en  <= 1'b0;
      dout_end <= 1'b0;
    end else begin
      dout_en  <= en1;
      dout_end <= end1;
      if (en1) begin
`ifdef AWB_APPLY_BYPASS_EN
        Dout <= bypass1 ? {pix1, tag1} : {satPix, tag1};
`else
        Dout <= {satPix, tag1};
`endif
      end
    end
  end

endmodule

// File: tb/tb_awb_gain_apply.sv
// tb_awb_gain_apply
//   Directed testbench for awb_gain_apply. Each task drives one scenario
//   and compares the outputs against hand-computed values.
//   With AWB_APPLY_BYPASS_EN defined the bypass port and its test are added.

module tb_awb_gain_apply;

  logic        clk;
  logic        rst_n;
  logic [15:0] Din;
  logic        data_en;
  logic        end_flag;
  logic [7:0]  rGain, gGain, bGain;
  logic        gain_vld;
`ifdef AWB_APPLY_BYPASS_EN
  logic        bypass;
`endif
  logic [15:0] Dout;
  logic        dout_en;
  logic        dout_end;
  logic        gain_pending;

  int errors;
  int checks;

  awb_gain_apply dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Din          (Din),
    .data_en      (data_en),
    .end_flag     (end_flag),
    .rGain        (rGain),
    .gGain        (gGain),
    .bGain        (bGain),
    .gain_vld     (gain_vld),
`ifdef AWB_APPLY_BYPASS_EN
    .bypass       (bypass),
`endif
    .Dout         (Dout),
    .dout_en      (dout_en),
    .dout_end     (dout_end),
    .gain_pending (gain_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task stepIdle();
    @(posedge clk);
    #1;
  endtask

  task stepPixel(input logic [15:0] d, input logic ef);
    Din      = d;
    data_en  = 1'b1;
    end_flag = ef;
    @(posedge clk);
    #1;
    Din      = '0;
    data_en  = 1'b0;
    end_flag = 1'b0;
  endtask

  task loadGains(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    rGain    = r;
    gGain    = g;
    bGain    = b;
    gain_vld = 1'b1;
    @(posedge clk);
    #1;
    gain_vld = 1'b0;
  endtask

  task test_reset();
    rst_n = 1'b0;
    stepIdle();
    stepIdle();
    checks++; if (Dout !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dout: got %h expected %h", Dout, 16'h0000); end
    checks++; if (dout_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_en: got %b expected 0", dout_en); end
    checks++; if (dout_end !== 1'b0) begin errors++; $display("[TB] FAIL reset_dout_end: got %b expected 0", dout_end); end
    checks++; if (gain_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0", gain_pending); end
    rst_n = 1'b1;
    stepIdle();
  endtask

  task test_unity();
    stepPixel(16'h8004, 1'b1);
    checks++; if (dout_en !== 1'b0) begin errors++; $display("[TB] FAIL unity_early_en: got %b expected 0", dout_en); end
    stepIdle();
    checks++; if (Dout !== 16'h8004) begin errors++; $display("[TB] FAIL unity_dout: got %h expected %h", Dout, 16'h8004); end
    checks++; if (dout_en !== 1'b1) begin errors++; $display("[TB] FAIL unity_en: got %b expected 1", dout_en); end
    checks++; if (dout_end !== 1'b1) begin errors++; $display("[TB] FAIL unity_end: got %b expected 1", dout_end); end
    stepIdle();
    checks++; if (dout_en !== 1'b0) begin errors++; $display("[TB] FAIL unity_en_drop: got %b expected 0", dout_en); end
    checks++; if (Dout !== 16'h8004) begin errors++; $display("[TB] FAIL unity_hold: got %h expected %h", Dout, 16'h8004); end
  endtask

  task test_saturate();
    loadGains(8'h80, 8'h40, 8'h40);
    checks++; if (gain_pending !== 1'b0) begin errors++; $display("[TB] FAIL idle_load_pending: got %b expected 0", gain_pending); end
    stepPixel(16'hA004, 1'b1);
    stepIdle();
    checks++; if (Dout !== 16'hFFF4) begin errors++; $display("[TB] FAIL sat_dout: got %h expected %h", Dout, 16'hFFF4); end
    stepPixel(16'h1004, 1'b1);
    stepIdle();
    checks++; if (Dout !== 16'h2004) begin errors++; $display("[TB] FAIL double_dout: got %h expected %h", Dout, 16'h2004); end
  endtask

  task test_channel_select();
    logic [15:0] vin  [6];
    logic [15:0] vexp [6];
    loadGains(8'h80, 8'h20, 8'h41);
    vin[0] = 16'h0202; vexp[0] = 16'h0212;  // B: 32*65 -> 33
    vin[1] = 16'h1008; vexp[1] = 16'h0808;  // G via bit3: 256*0.5
    vin[2] = 16'h1001; vexp[2] = 16'h0801;  // G via bit0
    vin[3] = 16'h1006; vexp[3] = 16'h2006;  // R wins over B
    vin[4] = 16'h100A; vexp[4] = 16'h104A;  // B wins over G: 256*65 -> 260
    vin[5] = 16'h1230; vexp[5] = 16'h1230;  // no tag -> unity
    for (int i = 0; i < 6; i++) begin
      stepPixel(vin[i], 1'b1);
      stepIdle();
      checks++; if (Dout !== vexp[i]) begin errors++; $display("[TB] FAIL chan_sel_%0d: got %h expected %h", i, Dout, vexp[i]); end
    end
  endtask

  task test_gain_zero();
    loadGains(8'h00, 8'h40, 8'h40);
    stepPixel(16'hFFF4, 1'b1);
    stepIdle();
    checks++; if (Dout !== 16'h0004) begin errors++; $display("[TB] FAIL zero_gain: got %h expected %h", Dout, 16'h0004); end
  endtask

  task test_back_to_back();
    loadGains(8'h80, 8'h40, 8'h20);
    stepPixel(16'h1004, 1'b0);
    stepPixel(16'h4002, 1'b0);
    checks++; if (Dout !== 16'h2004 || dout_en !== 1'b1 || dout_end !== 1'b0) begin errors++; $display("[TB] FAIL b2b_first: got %h/%b/%b expected 2004/1/0", Dout, dout_en, dout_end); end
    stepIdle();
    checks++; if (Dout !== 16'h2002 || dout_en !== 1'b1) begin errors++; $display("[TB] FAIL b2b_second: got %h/%b expected 2002/1", Dout, dout_en); end
    stepPixel(16'h0FF8, 1'b1);
    checks++; if (dout_en !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap_en: got %b expected 0", dout_en); end
    checks++; if (Dout !== 16'h2002) begin errors++; $display("[TB] FAIL b2b_gap_hold: got %h expected %h", Dout, 16'h2002); end
    stepIdle();
    checks++; if (Dout !== 16'h0FF8 || dout_en !== 1'b1 || dout_end !== 1'b1) begin errors++; $display("[TB] FAIL b2b_last: got %h/%b/%b expected 0ff8/1/1", Dout, dout_en, dout_end); end
    checks++; if (gain_pending !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pending: got %b expected 0", gain_pending); end
  endtask

  task test_frame_commit();
    loadGains(8'h40, 8'h40, 8'h40);
    stepPixel(16'h1004, 1'b0);
    loadGains(8'h20, 8'h40, 8'h40);
    checks++; if (gain_pending !== 1'b1) begin errors++; $display("[TB] FAIL commit_pending_set: got %b expected 1", gain_pending); end
    checks++; if (Dout !== 16'h1004) begin errors++; $display("[TB] FAIL commit_mid_pixel: got %h expected %h", Dout, 16'h1004); end
    stepPixel(16'h1004, 1'b1);
    checks++; if (gain_pending !== 1'b0) begin errors++; $display("[TB] FAIL commit_pending_clr: got %b expected 0", gain_pending); end
    stepIdle();
    checks++; if (Dout !== 16'h1004 || dout_end !== 1'b1) begin errors++; $display("[TB] FAIL commit_end_pixel: got %h/%b expected 1004/1", Dout, dout_end); end
    stepPixel(16'h1004, 1'b1);
    stepIdle();
    checks++; if (Dout !== 16'h0804) begin errors++; $display("[TB] FAIL commit_next_frame: got %h expected %h", Dout, 16'h0804); end
  endtask

  task test_commit_coincide();
    stepPixel(16'h1004, 1'b0);
    rGain    = 8'h80;
    gGain    = 8'h40;
    bGain    = 8'h40;
    gain_vld = 1'b1;
    stepPixel(16'h1004, 1'b1);
    gain_vld = 1'b0;
    checks++; if (gain_pending !== 1'b0) begin errors++; $display("[TB] FAIL coincide_pending: got %b expected 0", gain_pending); end
    stepIdle();
    checks++; if (Dout !== 16'h0804) begin errors++; $display("[TB] FAIL coincide_end_pixel: got %h expected %h", Dout, 16'h0804); end
    stepPixel(16'h1004, 1'b1);
    stepIdle();
    checks++; if (Dout !== 16'h2004) begin errors++; $display("[TB] FAIL coincide_next: got %h expected %h", Dout, 16'h2004); end
  endtask

  task test_reset_inflight();
    stepPixel(16'h1004, 1'b0);
    loadGains(8'h10, 8'h10, 8'h10);
    checks++; if (gain_pending !== 1'b1) begin errors++; $display("[TB] FAIL inflight_pending_pre: got %b expected 1", gain_pending); end
    stepPixel(16'h3004, 1'b0);
    Din     = 16'h5004;
    data_en = 1'b1;
    stepIdle();
    data_en = 1'b0;
    Din     = '0;
    rst_n   = 1'b0;
    #1;
    checks++; if (Dout !== 16'h0000 || dout_en !== 1'b0 || dout_end !== 1'b0) begin errors++; $display("[TB] FAIL inflight_in_reset: got %h/%b/%b expected 0000/0/0", Dout, dout_en, dout_end); end
    checks++; if (gain_pending !== 1'b0) begin errors++; $display("[TB] FAIL inflight_pending_rst: got %b expected 0", gain_pending); end
    stepIdle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepIdle();
      checks++; if (dout_en !== 1'b0 || Dout !== 16'h0000) begin errors++; $display("[TB] FAIL inflight_after_%0d: got %h/%b expected 0000/0", i, Dout, dout_en); end
    end
    stepPixel(16'h1004, 1'b1);
    stepIdle();
    checks++; if (Dout !== 16'h1004 || dout_en !== 1'b1) begin errors++; $display("[TB] FAIL inflight_unity: got %h/%b expected 1004/1", Dout, dout_en); end
  endtask

`ifdef AWB_APPLY_BYPASS_EN
  task test_bypass();
    loadGains(8'h80, 8'h40, 8'h40);
    bypass = 1'b1;
    stepPixel(16'hA004, 1'b1);
    bypass = 1'b0;
    checks++; if (dout_en !== 1'b0) begin errors++; $display("[TB] FAIL bypass_early: got %b expected 0", dout_en); end
    stepIdle();
    checks++; if (Dout !== 16'hA004 || dout_en !== 1'b1) begin errors++; $display("[TB] FAIL bypass_dout: got %h/%b expected a004/1", Dout, dout_en); end
    stepPixel(16'hA004, 1'b1);
    stepIdle();
    checks++; if (Dout !== 16'hFFF4) begin errors++; $display("[TB] FAIL bypass_off: got %h expected %h", Dout, 16'hFFF4); end
  endtask
`endif

  initial begin
    errors   = 0;
    checks   = 0;
    rst_n    = 1'b0;
    Din      = '0;
    data_en  = 1'b0;
    end_flag = 1'b0;
    rGain    = 8'h40;
    gGain    = 8'h40;
    bGain    = 8'h40;
    gain_vld = 1'b0;
`ifdef AWB_APPLY_BYPASS_EN
    bypass   = 1'b0;
`endif
    $display("[TB] awb_gain_apply directed test start");
    test_reset();
    test_unity();
    test_saturate();
    test_channel_select();
    test_gain_zero();
    test_back_to_back();
    test_frame_commit();
    test_commit_coincide();
    test_reset_inflight();
`ifdef AWB_APPLY_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
